// File: rtl/kt_pkg.sv
// Shared types and constants for the KnightsTour remote command link.
package kt_pkg;

  // Command assembly: waiting for the high byte or for the low byte.
  typedef enum logic {WAIT_HI, WAIT_LO} cmd_asm_t;

  localparam logic [7:0]  RESP_ACK        = 8'hA5;
  localparam logic [15:0] CMD_CAL         = 16'h2000;
  localparam int          UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_byte_xcvr.sv
// 8N1 UART byte transceiver: independent RX deserializer and TX serializer.
module uart_byte_xcvr
  import kt_pkg::*;
#(
  parameter int BAUD_CYCLES = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_rdy_o,
  output logic       rx_ferr_o,
  output logic       rx_busy_o,
  output logic [7:0] rx_data_o,
  input  logic [7:0] tx_data_i,
  input  logic       trmt_i,
  output logic       tx_o,
  output logic       tx_done_o
);

  localparam int CW = (BAUD_CYCLES > 2) ? $clog2(BAUD_CYCLES) : 1;
  localparam int BW = $clog2(UART_FRAME_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_FRAME_BITS - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_busy_q, rx_rdy_q, rx_ferr_q;
  logic [CW-1:0] rx_cnt_q;
  logic [BW-1:0] rx_bit_q;
  logic [7:0]    rx_shift_q;

  logic          tx_busy_q, tx_q, tx_done_q;
  logic [CW-1:0] tx_cnt_q;
  logic [BW-1:0] tx_bit_q;
  logic [8:0]    tx_shift_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX: detect start edge, sample mid-bit, shift data LSB first, judge stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_busy_q  <= 1'b0;
      rx_rdy_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_rdy_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HALF_LAST;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= BAUD_LAST;
        rx_bit_q <= rx_bit_q + 1'b1;
        if (rx_bit_q == '0) begin
          // Line back high at mid start bit: treat as a glitch.
          if (rx_sync_q) rx_busy_q <= 1'b0;
        end else if (rx_bit_q == BIT_LAST) begin
          rx_busy_q <= 1'b0;
          if (rx_sync_q) rx_rdy_q  <= 1'b1;
          else           rx_ferr_q <= 1'b1;
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  // TX: latch frame on trmt when idle, emit one bit per baud period, flag done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (!tx_busy_q) begin
      if (trmt_i) begin
        tx_busy_q  <= 1'b1;
        tx_q       <= 1'b0;
        tx_done_q  <= 1'b0;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        tx_shift_q <= {1'b1, tx_data_i};
      end
    end else if (tx_cnt_q != BAUD_LAST) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q <= '0;
      if (tx_bit_q == BIT_LAST) begin
        tx_busy_q <= 1'b0;
        tx_q      <= 1'b1;
        tx_done_q <= 1'b1;
      end else begin
        tx_q       <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bit_q   <= tx_bit_q + 1'b1;
      end
    end
  end

  assign rx_rdy_o  = rx_rdy_q;
  assign rx_ferr_o = rx_ferr_q;
  assign rx_busy_o = rx_busy_q;
  assign rx_data_o = rx_shift_q;
  assign tx_o      = tx_q;
  assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Robot-side command link: assembles 2-byte commands from UART and sends response bytes.
module uart_cmd_wrapper
  import kt_pkg::*;
#(
  parameter int BAUD_CYCLES = 5208,
  parameter int BYTE_TMO    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int TW = $clog2(BYTE_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TMO - 1);

  logic       rx_rdy, rx_ferr, rx_busy;
  logic [7:0] rx_data;

  cmd_asm_t      state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;

  uart_byte_xcvr #(.BAUD_CYCLES(BAUD_CYCLES)) u_xcvr (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .rx_rdy_o  (rx_rdy),
    .rx_ferr_o (rx_ferr),
    .rx_busy_o (rx_busy),
    .rx_data_o (rx_data),
    .tx_data_i (resp),
    .trmt_i    (trmt),
    .tx_o      (TX),
    .tx_done_o (tx_done)
  );

  // Assembly state, inter-byte timeout and command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_HI;
      tmo_q     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Next-state: pair bytes into a command; framing errors and idle timeout drop the high byte.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    tmo_d     = '0;
    // Clear first so a completing command in the same cycle overrides it.
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          cmd_d[15:8] = rx_data;
          cmd_rdy_d   = 1'b0;
          state_d     = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d[7:0] = rx_data;
          cmd_rdy_d  = 1'b1;
          state_d    = WAIT_HI;
        end else if (rx_ferr) begin
          state_d = WAIT_HI;
        end else if (!rx_busy) begin
          if (tmo_q == TMO_LAST) state_d = WAIT_HI;
          else                   tmo_d   = tmo_q + 1'b1;
        end
      end
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: acts as remoteComm on RX/TX and as cmd_proc.
module tb_uart_cmd_wrapper;
  import kt_pkg::*;

  localparam int B    = 16;
  localparam int HALF = B / 2;
  localparam int TMO  = 400;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int checks   = 0;
  int failures = 0;

  // Reference model of the command link at byte level.
  logic        m_pending;
  logic [15:0] m_cmd;
  logic        m_rdy;

  uart_cmd_wrapper #(.BAUD_CYCLES(B), .BYTE_TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_cmd     = 16'h0000;
    m_rdy     = 1'b0;
  endtask

  // A good byte either starts a pair or completes it; a bad byte abandons any pair.
  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_cmd[7:0] = b;
      m_rdy      = 1'b1;
      m_pending  = 1'b0;
    end else begin
      m_cmd[15:8] = b;
      m_rdy       = 1'b0;
      m_pending   = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) tick();
    if (m_pending && n > TMO) m_pending = 1'b0;
  endtask

  // Drive one 8N1 frame; optionally hold clr_cmd_rdy high while cmd_rdy is low during the stop bit.
  task automatic send_byte(input string tag, input logic [7:0] b, input logic stop,
                           input logic hammer, output int rise);
    logic prev;
    rise = -1;
    RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) tick();
    end
    RX   = stop;
    prev = cmd_rdy;
    for (int c = 0; c < B; c++) begin
      clr_cmd_rdy = hammer && !cmd_rdy;
      tick();
      if (cmd_rdy && !prev && rise < 0) rise = c;
      prev = cmd_rdy;
    end
    clr_cmd_rdy = 1'b0;
    RX = 1'b1;
    model_byte(b, stop);
    check({tag, "_rdy"}, cmd_rdy, m_rdy);
    check({tag, "_cmd"}, cmd, m_cmd);
  endtask

  task automatic send_cmd(input string tag, input logic [15:0] c, input int gap);
    int r;
    send_byte({tag, "_hi"}, c[15:8], 1'b1, 1'b0, r);
    idle(gap);
    send_byte({tag, "_lo"}, c[7:0], 1'b1, 1'b0, r);
    idle(gap);
  endtask

  // Pulse trmt and act as the remote receiver; optionally pulse trmt again mid-frame.
  task automatic tx_frame(input string tag, input logic [7:0] r, input int inj_cyc,
                          input logic [7:0] inj_r);
    logic [9:0] frame;
    logic [7:0] got;
    frame = {1'b1, r, 1'b0};
    got   = 8'h00;
    resp  = r;
    trmt  = 1'b1;
    tick();
    trmt = 1'b0;
    check({tag, "_start"}, TX, 1'b0);
    check({tag, "_done_clr"}, tx_done, 1'b0);
    for (int k = 0; k < 10 * B; k++) begin
      if (k % B == HALF) begin
        check($sformatf("%s_bit%0d", tag, k / B), TX, frame[k / B]);
        if (k / B >= 1 && k / B <= 8) got[k / B - 1] = TX;
      end
      if (k == 10 * B - 1) check({tag, "_busy"}, tx_done, 1'b0);
      trmt = (k == inj_cyc);
      if (k == inj_cyc) resp = inj_r;
      tick();
    end
    trmt = 1'b0;
    check({tag, "_byte"}, got, r);
    check({tag, "_idle"}, TX, 1'b1);
    check({tag, "_done"}, tx_done, 1'b1);
  endtask

  initial begin
    int rise;
    logic [15:0] rc;
    logic [7:0]  rr;

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = 8'h00;
    model_reset();
    #1;
    check("rst_tx", TX, 1'b1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_rdy", cmd_rdy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    idle(20);

    // 1: calibrate command, latency window, consume.
    send_byte("t1_hi", CMD_CAL[15:8], 1'b1, 1'b0, rise);
    idle(10);
    send_byte("t1_lo", CMD_CAL[7:0], 1'b1, 1'b0, rise);
    check("t1_rise_window", (rise >= HALF && rise <= HALF + 6), 1'b1);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("t1_clr", cmd_rdy, m_rdy);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    check("t1_clr_idle_rdy", cmd_rdy, 1'b0);
    check("t1_clr_idle_cmd", cmd, CMD_CAL);
    idle(10);

    // 2: new command while previous still unconsumed.
    send_cmd("t1b", CMD_CAL, 5);
    send_cmd("t2", 16'h43F2, 7);

    // 3: bad-framed high byte is never reported.
    send_byte("t3_bad", 8'h43, 1'b0, 1'b0, rise);
    idle(20);
    send_cmd("t3", CMD_CAL, 9);

    // 4: lone high byte times out.
    send_byte("t4_lone", 8'h43, 1'b1, 1'b0, rise);
    idle(TMO + 200);
    check("t4_after_tmo_rdy", cmd_rdy, 1'b0);
    send_cmd("t4", CMD_CAL, 3);

    // Completion and clear in the same cycle: set wins.
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    send_byte("col_hi", 8'h5C, 1'b1, 1'b0, rise);
    send_byte("col_lo", 8'h81, 1'b1, 1'b1, rise);
    idle(10);

    // 5: ack response.
    tx_frame("t5", RESP_ACK, -1, 8'h00);
    // 6: second trmt mid-frame ignored.
    tx_frame("t6", RESP_ACK, 3 * B + 5, 8'h5A);

    // 6: reset during both an RX and a TX frame.
    resp = 8'h3C; trmt = 1'b1;
    tick();
    trmt = 1'b0;
    RX = 1'b0;
    repeat (B) tick();
    RX = 1'b0;
    repeat (2 * B + 3) tick();
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_rst_tx", TX, 1'b1);
    check("t6_rst_rdy", cmd_rdy, 1'b0);
    check("t6_rst_done", tx_done, 1'b0);
    check("t6_rst_cmd", cmd, 16'h0000);
    RX = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(20);
    send_cmd("t6_post", CMD_CAL, 4);

    // Randomized commands with occasional bad frames and random gaps.
    for (int n = 0; n < 8; n++) begin
      rc = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rr = 8'($urandom);
        send_byte("rnd_bad", rr, 1'b0, 1'b0, rise);
        idle($urandom_range(2, 40));
      end
      send_cmd("rnd", rc, $urandom_range(0, 150));
    end

    // Randomized responses, some with a stray mid-frame trmt.
    for (int n = 0; n < 3; n++) begin
      rr = 8'($urandom);
      tx_frame("rnd_tx", rr, (n == 1) ? $urandom_range(B, 9 * B) : -1, 8'($urandom));
      idle($urandom_range(0, 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
